// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin multi-master arbiter in front of a word-addressed memory
// One transaction is in flight at a time: IDLE latches a winner, WAIT pads latency, DONE responds.
module mem_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int DEPTH     = 1024,
  parameter int LATENCY   = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_PORTS-1:0]    req,
  input  logic [NUM_PORTS-1:0]    rw,
  input  logic [32*NUM_PORTS-1:0] addr,
  input  logic [32*NUM_PORTS-1:0] wdata,
  output logic [NUM_PORTS-1:0]    ready,
  output logic [32*NUM_PORTS-1:0] rdata,
  output logic                    busy,
  output logic [2:0]              grant
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [3:0] CNT_LAST  = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
  localparam logic [3:0] NP        = 4'(NUM_PORTS);
  localparam logic [2:0] LAST_PORT = 3'(NUM_PORTS - 1);

  logic [1:0]    state_q, state_d;
  logic [2:0]    ptr_q, ptr_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [2:0]    win_q, win_d;
  logic          rw_q, rw_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   wdata_q, wdata_d;

  logic [31:0] mem [DEPTH];

  logic [7:0]  req_ext;
  logic        req_any;
  logic [2:0]  pick;
  logic [3:0]  cand;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_rw;
  logic [31:0] unused_sel_addr;

  // Scan from lowest priority to highest so the last hit is the winner.
  always_comb begin
    req_ext = 8'(req);
    req_any = |req;
    pick    = ptr_q;
    cand    = 4'd0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      cand = {1'b0, ptr_q} + 4'(k);
      if (cand >= NP) cand = cand - NP;
      if (req_ext[cand[2:0]]) pick = cand[2:0];
    end
  end

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_rw    = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (pick == 3'(i)) begin
        sel_addr  = addr[32*i +: 32];
        sel_wdata = wdata[32*i +: 32];
        sel_rw    = rw[i];
      end
    end
  end

  assign unused_sel_addr = sel_addr;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    rw_d    = rw_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (req_any) begin
          win_d   = pick;
          rw_d    = sel_rw;
          idx_d   = sel_addr[2 +: AW];
          wdata_d = sel_wdata;
          ptr_d   = (pick == LAST_PORT) ? 3'd0 : pick + 3'd1;
          cnt_d   = 4'd0;
          state_d = (LATENCY > 0) ? WAIT : DONE;
        end
      end
      WAIT: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = 4'd0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= 3'd0;
      cnt_q   <= 4'd0;
      win_q   <= 3'd0;
      rw_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      rw_q    <= rw_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
    end
  end

  // Storage survives reset; a reset on the DONE edge suppresses the write.
  always_ff @(posedge clock) begin
    if (reset && state_q == DONE && rw_q) mem[idx_q] <= wdata_q;
  end

  always_comb begin
    ready = '0;
    rdata = '0;
    if (state_q == DONE) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (win_q == 3'(i)) begin
          ready[i] = 1'b1;
          if (!rw_q) rdata[32*i +: 32] = mem[idx_q];
        end
      end
    end
  end

  assign busy  = (state_q != IDLE);
  assign grant = busy ? win_q : 3'd0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
// Table vectors, hand-written corner sequences and a randomized two-master run against a reference model.
module tb_mem_arbiter;
  localparam int NP    = 2;
  localparam int DEPTH = 1024;
  localparam int LAT   = 1;

  logic            clock = 1'b0;
  logic            reset;
  logic [NP-1:0]   req, rw, ready;
  logic [32*NP-1:0] addr, wdata, rdata;
  logic            busy;
  logic [2:0]      grant;

  logic            reset0;
  logic [1:0]      req0, rw0, ready0;
  logic [63:0]     addr0, wdata0, rdata0;
  logic            busy0;
  logic [2:0]      grant0;

  mem_arbiter #(.NUM_PORTS(NP), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clock(clock), .reset(reset), .req(req), .rw(rw), .addr(addr), .wdata(wdata),
    .ready(ready), .rdata(rdata), .busy(busy), .grant(grant)
  );

  mem_arbiter #(.NUM_PORTS(2), .DEPTH(16), .LATENCY(0)) dut0 (
    .clock(clock), .reset(reset0), .req(req0), .rw(rw0), .addr(addr0), .wdata(wdata0),
    .ready(ready0), .rdata(rdata0), .busy(busy0), .grant(grant0)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h, required %h", nm, act, exp);
    end
  endtask

  // Reference model: transactions served one at a time, round-robin pick, fixed occupancy.
  logic [31:0] mem_model [int];
  bit          model_on = 1'b0;
  bit          gen_on   = 1'b0;
  bit          pending  = 1'b0;
  int          m_cnt    = 0;
  int          rr_ptr   = 0;
  int          m_port   = 0;
  bit          m_rw     = 1'b0;
  int          m_idx    = 0;
  logic [31:0] m_wdata  = '0;
  int          served   = 0;

  always @(posedge clock) begin
    if (model_on) begin
      if (pending) begin
        if (m_cnt > 0) m_cnt--;
        else pending = 1'b0;
      end else if (req != '0) begin
        m_port = -1;
        for (int k = 0; k < NP; k++)
          if (m_port < 0 && req[(rr_ptr + k) % NP]) m_port = (rr_ptr + k) % NP;
        rr_ptr  = (m_port + 1) % NP;
        m_rw    = rw[m_port];
        m_idx   = int'((addr[32*m_port +: 32] >> 2) % DEPTH);
        m_wdata = wdata[32*m_port +: 32];
        m_cnt   = LAT;
        pending = 1'b1;
        served++;
      end
    end
  end

  always @(negedge clock) begin
    logic [NP-1:0] er;
    int unsigned   wi;
    if (model_on) begin
      er = '0;
      if (pending && m_cnt == 0) er[m_port] = 1'b1;
      check("rand_ready", 32'(ready), 32'(er));
      check("rand_busy", 32'(busy), 32'(pending));
      check("rand_grant", 32'(grant), pending ? 32'(m_port) : 32'h0);
      for (int i = 0; i < NP; i++)
        check("rand_rdata", rdata[32*i +: 32], (er[i] && !m_rw) ? mem_model[m_idx] : 32'h0);
      if (er != '0 && m_rw) mem_model[m_idx] = m_wdata;
      for (int i = 0; i < NP; i++) begin
        if (req[i] && ready[i]) begin
          req[i] = 1'b0;
        end else if (gen_on && !req[i] && $urandom_range(0, 2) == 0) begin
          wi = $urandom_range(0, 15);
          req[i] = 1'b1;
          rw[i]  = 1'($urandom_range(0, 1));
          addr[32*i +: 32]  = ($urandom & 32'hFFFF_F003) | (wi << 2);
          wdata[32*i +: 32] = $urandom;
        end
      end
    end
  end

  // Called at a negedge while the arbiter is idle; returns at the negedge of the following idle cycle.
  task automatic txn(input int p, input bit wr, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] exp_rd, input string nm);
    int w;
    req[p] = 1'b1; rw[p] = wr; addr[32*p +: 32] = a; wdata[32*p +: 32] = d;
    w = 0;
    do begin @(negedge clock); w++; end while (!ready[p] && w < 40);
    check({nm, "_latency"}, 32'(w), 32'(LAT + 1));
    check({nm, "_grant"}, 32'(grant), 32'(p));
    check({nm, "_busy"}, 32'(busy), 32'h1);
    for (int i = 0; i < NP; i++)
      check({nm, "_rdata"}, rdata[32*i +: 32], (i == p) ? exp_rd : 32'h0);
    req[p] = 1'b0;
    if (wr) mem_model[int'((a >> 2) % DEPTH)] = d;
    @(negedge clock);
    check({nm, "_pulse"}, 32'(ready), 32'h0);
    check({nm, "_idle_busy"}, 32'(busy), 32'h0);
  endtask

  typedef struct {
    int          port;
    bit          wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vt [10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w, g, pulses;
    logic [31:0] cap;

    vt[0] = '{1, 1'b1, 32'h0000_0040, 32'hDEADBEEF, 32'h0};
    vt[1] = '{0, 1'b0, 32'h0000_0040, 32'h0,        32'hDEADBEEF};
    vt[2] = '{0, 1'b1, 32'h0000_1000, 32'h12345678, 32'h0};
    vt[3] = '{1, 1'b0, 32'h0000_0000, 32'h0,        32'h12345678};
    vt[4] = '{0, 1'b1, 32'h0000_0044, 32'h0BADF00D, 32'h0};
    vt[5] = '{1, 1'b0, 32'h0000_0047, 32'h0,        32'h0BADF00D};
    vt[6] = '{1, 1'b1, 32'h0000_0FFC, 32'hCAFEBABE, 32'h0};
    vt[7] = '{0, 1'b0, 32'hFFFF_FFFC, 32'h0,        32'hCAFEBABE};
    vt[8] = '{1, 1'b1, 32'h0000_0100, 32'h89ABCDEF, 32'h0};
    vt[9] = '{0, 1'b0, 32'h0000_0100, 32'h0,        32'h89ABCDEF};

    reset = 1'b0; reset0 = 1'b0;
    req = '1; rw = '0; addr = '0; wdata = '0;
    req0 = '0; rw0 = '0; addr0 = '0; wdata0 = '0;
    repeat (2) @(negedge clock);
    check("reset_ready", 32'(ready), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_grant", 32'(grant), 32'h0);
    check("reset_rdata_lo", rdata[31:0], 32'h0);
    check("reset_rdata_hi", rdata[63:32], 32'h0);
    req = '0; reset = 1'b1; reset0 = 1'b1;

    for (int v = 0; v < 10; v++)
      txn(vt[v].port, vt[v].wr, vt[v].a, vt[v].d, vt[v].exp_rd, $sformatf("vec%0d", v));

    // Zero-latency instance: response one edge after sampling, busy for that cycle only.
    req0 = 2'b01; rw0 = 2'b01; addr0[31:0] = 32'h8; wdata0[31:0] = 32'h55AA55AA;
    w = 0;
    do begin @(negedge clock); w++; end while (!ready0[0] && w < 20);
    check("lat0_wr_latency", 32'(w), 32'h1);
    check("lat0_wr_busy", 32'(busy0), 32'h1);
    req0 = '0;
    @(negedge clock);
    check("lat0_wr_pulse", 32'(ready0), 32'h0);
    rw0 = 2'b00; addr0[31:0] = 32'h48; req0 = 2'b01;
    check("lat0_busy_before", 32'(busy0), 32'h0);
    @(negedge clock);
    check("lat0_rd_ready", 32'(ready0), 32'h1);
    check("lat0_rd_busy", 32'(busy0), 32'h1);
    check("lat0_rd_data", rdata0[31:0], 32'h55AA55AA);
    check("lat0_rd_other", rdata0[63:32], 32'h0);
    req0 = '0;
    @(negedge clock);
    check("lat0_busy_after", 32'(busy0), 32'h0);
    check("lat0_rdata_after", rdata0[31:0], 32'h0);

    // Both masters requesting continuously after reset alternate 0,1,0,1.
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    rw = '0; addr = {32'h44, 32'h40}; req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      w = 0;
      do begin @(negedge clock); w++; end while (ready == '0 && w < 20);
      check("rr_grant", 32'(grant), 32'(k % 2));
      check("rr_ready", 32'(ready), 32'(1 << (k % 2)));
      g = int'(grant);
      req[g % NP] = 1'b0;
      if (k < 3) begin
        @(negedge clock);
        req[g % NP] = 1'b1;
      end
    end
    req = '0;
    @(negedge clock);

    // Master drops req and changes addr while its read is in flight.
    rw[0] = 1'b0; addr[31:0] = 32'h40; req[0] = 1'b1;
    @(negedge clock);
    req[0] = 1'b0; addr[31:0] = 32'h44;
    pulses = 0; cap = '0;
    repeat (6) begin
      @(negedge clock);
      if (ready[0]) begin pulses++; cap = rdata[31:0]; end
    end
    check("latched_pulses", 32'(pulses), 32'h1);
    check("latched_rdata", cap, 32'hDEADBEEF);

    // Reset during WAIT aborts the write.
    txn(0, 1'b1, 32'h80, 32'h11111111, 32'h0, "abort_pre");
    rw[0] = 1'b1; addr[31:0] = 32'h80; wdata[31:0] = 32'hA5A5A5A5; req[0] = 1'b1;
    @(negedge clock);
    check("abort_busy_wait", 32'(busy), 32'h1);
    reset = 1'b0; req[0] = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_grant", 32'(grant), 32'h0);
    pulses = 0;
    repeat (4) begin
      @(negedge clock);
      if (ready != '0) pulses++;
    end
    check("abort_no_ready", 32'(pulses), 32'h0);
    txn(1, 1'b0, 32'h80, 32'h0, 32'h11111111, "abort_readback");

    // Randomized two-master traffic over 16 known words.
    for (int i = 0; i < 16; i++)
      txn(i % 2, 1'b1, 32'(i * 4), $urandom, 32'h0, "prefill");
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    rr_ptr = 0; pending = 1'b0; m_cnt = 0; served = 0;
    model_on = 1'b1; gen_on = 1'b1;
    repeat (3000) @(negedge clock);
    gen_on = 1'b0;
    repeat (30) @(negedge clock);
    model_on = 1'b0;
    check("rand_served", 32'(served > 200), 32'h1);
    check("rand_drained", 32'(busy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
